// File: rtl/memory_rw_if.sv
// Bus bundle for memory_rw: one write request port and one pipelined read
// port with response flags. The master issues requests, the slave is the memory.
interface memory_rw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // Read request / response
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_adr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic                      rd_err;

    // Write request / error pulse
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_adr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_be;
    logic                      wr_err;

    modport master (
        output rd_en, rd_adr, wr_en, wr_adr, wr_data, wr_be,
        input  rd_data, rd_valid, rd_err, wr_err
    );

    modport slave (
        input  rd_en, rd_adr, wr_en, wr_adr, wr_data, wr_be,
        output rd_data, rd_valid, rd_err, wr_err
    );
endinterface

// File: rtl/memory_rw.sv
// Single-clock word memory with byte-enable writes and a 1- or 2-stage
// pipelined read port. Out-of-range accesses never touch the array; they are
// flagged instead (rd_err on the response, wr_err one cycle after the write).
module memory_rw #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 8,
    parameter int    MAX_MEM_SIZE = 128,
    parameter int    RD_LATENCY   = 1,
    parameter bit    BYPASS       = 1'b1,
    parameter string FILE_INPUT   = "./sim/file/new_test.txt"
) (
    input  logic       clk,
    input  logic       rst_n,
    memory_rw_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (MAX_MEM_SIZE > 1) ? $clog2(MAX_MEM_SIZE) : 1;
    // One extra bit so a limit of exactly 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MAX_MEM_SIZE);

    // Reject illegal configurations at elaboration time.
    if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
        $fatal(1, "memory_rw: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
        $fatal(1, "memory_rw: RD_LATENCY must be 1 or 2");
    end
    if (longint'(MAX_MEM_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_chk_size
        $fatal(1, "memory_rw: MAX_MEM_SIZE exceeds 2^ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [MAX_MEM_SIZE];

    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic                  w_wr_fire;
    logic                  w_bypass_hit;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Full-width compare: no modulo wrap of addresses beyond the array.
    assign w_rd_in_range = ({1'b0, bus.rd_adr} < MEM_LIMIT);
    assign w_wr_in_range = ({1'b0, bus.wr_adr} < MEM_LIMIT);
    assign w_rd_idx      = bus.rd_adr[IDX_W-1:0];
    assign w_wr_idx      = bus.wr_adr[IDX_W-1:0];
    assign w_wr_fire     = bus.wr_en && w_wr_in_range;
    assign w_rd_old      = r_mem[w_rd_idx];

    // Post-write view of the read word: enabled bytes from wr_data, rest old.
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_merge
        assign w_rd_merged[gi*8 +: 8] = bus.wr_be[gi] ? bus.wr_data[gi*8 +: 8]
                                                      : w_rd_old[gi*8 +: 8];
    end

    // A same-edge write to the read address only matters when bypassing.
    assign w_bypass_hit = BYPASS && w_wr_fire && (bus.wr_adr == bus.rd_adr);
    assign w_rd_word    = w_bypass_hit ? w_rd_merged : w_rd_old;

    // Byte-lane array update; nothing is accepted while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_fire) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (bus.wr_be[i]) begin
                    r_mem[w_wr_idx][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
                end
            end
        end
    end

    logic r_wr_err;

    // One-cycle flag for a write that fell outside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= bus.wr_en && !w_wr_in_range;
        end
    end

    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;

    // First read stage: capture the response on acceptance; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= bus.rd_en;
            r_s1_err   <= bus.rd_en && !w_rd_in_range;
            if (bus.rd_en) begin
                r_s1_data <= w_rd_in_range ? w_rd_word : '0;
            end
        end
    end

    logic                  w_out_valid;
    logic                  w_out_err;
    logic [DATA_WIDTH-1:0] w_out_data;

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_s2_valid;
        logic                  r_s2_err;
        logic [DATA_WIDTH-1:0] r_s2_data;

        // Second read stage: shift responses along, holding data between them.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_err   <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_err   <= r_s1_err;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign w_out_valid = r_s2_valid;
        assign w_out_err   = r_s2_err;
        assign w_out_data  = r_s2_data;
    end else begin : g_lat1
        assign w_out_valid = r_s1_valid;
        assign w_out_err   = r_s1_err;
        assign w_out_data  = r_s1_data;
    end

    assign bus.rd_valid = w_out_valid;
    assign bus.rd_err   = w_out_err;
    assign bus.rd_data  = w_out_data;
    assign bus.wr_err   = r_wr_err;
endmodule

// File: tb/tb_memory_rw.sv
// Randomised bench for memory_rw. Two instances share the same stimulus:
// dut_a (latency 1, new-data bypass) and dut_b (latency 2, old-data policy).
// A word-level model predicts every response and the cycle it should appear.
module tb_memory_rw;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int MEM = 128;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;

    memory_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    memory_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    memory_rw #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_MEM_SIZE(MEM),
        .RD_LATENCY(1), .BYPASS(1'b1), .FILE_INPUT("")
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    memory_rw #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_MEM_SIZE(MEM),
        .RD_LATENCY(2), .BYPASS(1'b0), .FILE_INPUT("")
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] mem_m [MEM];
    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] last_d [2];
    string       dut_name [2] = '{"lat1_byp1", "lat2_byp0"};
    int          cyc;
    int          wr_err_due;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return m;
    endfunction

    task automatic check_dut(input int k, input logic gv, input logic ge,
                             input logic [31:0] gd, input logic gw);
        resp_t r;
        bit    hit;
        hit = 1'b0;
        r.due = 0; r.data = '0; r.err = 1'b0;
        if (k == 0) begin
            if (q0.size() != 0 && q0[0].due == cyc) begin r = q0.pop_front(); hit = 1'b1; end
        end else begin
            if (q1.size() != 0 && q1[0].due == cyc) begin r = q1.pop_front(); hit = 1'b1; end
        end
        if (hit) begin
            check($sformatf("%s.rd_valid", dut_name[k]), 32'(gv), 32'd1);
            check($sformatf("%s.rd_err", dut_name[k]), 32'(ge), 32'(r.err));
            check($sformatf("%s.rd_data", dut_name[k]), gd, r.data);
            last_d[k] = r.data;
        end else begin
            check($sformatf("%s.rd_valid_idle", dut_name[k]), 32'(gv), 32'd0);
            check($sformatf("%s.rd_err_idle", dut_name[k]), 32'(ge), 32'd0);
            check($sformatf("%s.rd_data_hold", dut_name[k]), gd, last_d[k]);
        end
        check($sformatf("%s.wr_err", dut_name[k]), 32'(gw), 32'(wr_err_due == cyc));
    endtask

    task automatic check_outputs();
        check_dut(0, bus_a.rd_valid, bus_a.rd_err, bus_a.rd_data, bus_a.wr_err);
        check_dut(1, bus_b.rd_valid, bus_b.rd_err, bus_b.rd_data, bus_b.wr_err);
    endtask

    // One clock of stimulus: drive, predict, clock, then check at the falling edge.
    task automatic step(input bit re, input int ra, input bit we, input int wa,
                        input logic [31:0] wd, input logic [3:0] be);
        resp_t       r_a;
        resp_t       r_b;
        logic [31:0] old_w;
        bus_a.rd_en = re;  bus_a.rd_adr = 8'(ra);
        bus_a.wr_en = we;  bus_a.wr_adr = 8'(wa); bus_a.wr_data = wd; bus_a.wr_be = be;
        bus_b.rd_en = re;  bus_b.rd_adr = 8'(ra);
        bus_b.wr_en = we;  bus_b.wr_adr = 8'(wa); bus_b.wr_data = wd; bus_b.wr_be = be;
        if (rst_n) begin
            if (re) begin
                if (ra < MEM) begin
                    old_w     = mem_m[ra];
                    r_b.data  = old_w;
                    r_a.data  = (we && wa == ra) ? merge(old_w, wd, be) : old_w;
                    r_a.err   = 1'b0;
                    r_b.err   = 1'b0;
                end else begin
                    r_a.data = '0; r_a.err = 1'b1;
                    r_b.data = '0; r_b.err = 1'b1;
                end
                r_a.due = cyc + 1;
                r_b.due = cyc + 2;
                q0.push_back(r_a);
                q1.push_back(r_b);
            end
            if (we) begin
                if (wa < MEM) mem_m[wa] = merge(mem_m[wa], wd, be);
                else          wr_err_due = cyc + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        last_d[0] = '0;
        last_d[1] = '0;
        wr_err_due = -1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; wr_err_due = -1;
        last_d[0] = '0; last_d[1] = '0;
        bus_a.rd_en = 1'b0; bus_a.rd_adr = '0; bus_a.wr_en = 1'b0;
        bus_a.wr_adr = '0; bus_a.wr_data = '0; bus_a.wr_be = '0;
        bus_b.rd_en = 1'b0; bus_b.rd_adr = '0; bus_b.wr_en = 1'b0;
        bus_b.wr_adr = '0; bus_b.wr_data = '0; bus_b.wr_be = '0;
        rst_n = 1'b1;
        #1;
        assert_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known contents via full-word writes, including the values the
        // directed cases rely on.
        for (int i = 0; i < MEM; i++) begin
            logic [31:0] d;
            if (i < 4)       d = 32'(i + 1) * 32'h11;
            else if (i == 5) d = 32'h11223344;
            else if (i == 7) d = 32'h0;
            else             d = $urandom;
            step(1'b0, 0, 1'b1, i, d, 4'hF);
        end

        // Back-to-back reads of 0..3, then idle hold of the last value.
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 0, 32'h0, 4'h0);
        idle(5);
        check("idle_hold_a", bus_a.rd_data, 32'h44);
        check("idle_hold_b", bus_b.rd_data, 32'h44);

        // Byte-enable merge.
        step(1'b0, 0, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
        step(1'b1, 5, 1'b0, 0, 32'h0, 4'h0);
        check("be_merge_a", bus_a.rd_data, 32'h11BB33DD);
        idle(1);
        check("be_merge_b", bus_b.rd_data, 32'h11BB33DD);

        // Same-edge read and write of address 7.
        step(1'b1, 7, 1'b1, 7, 32'hFFFFFFFF, 4'hF);
        check("rdw_new_a", bus_a.rd_data, 32'hFFFFFFFF);
        step(1'b1, 7, 1'b0, 0, 32'h0, 4'h0);
        check("rdw_old_b", bus_b.rd_data, 32'h00000000);
        idle(1);
        check("rdw_after_b", bus_b.rd_data, 32'hFFFFFFFF);

        // Out-of-range read and write.
        step(1'b1, 200, 1'b0, 0, 32'h0, 4'h0);
        check("oor_rd_err_a", 32'(bus_a.rd_err), 32'd1);
        step(1'b0, 0, 1'b1, 130, 32'h12345678, 4'hF);
        check("oor_wr_err_a", 32'(bus_a.wr_err), 32'd1);
        idle(2);

        // Reset while latency-2 reads are in flight; requests during reset ignored.
        step(1'b1, 0, 1'b0, 0, 32'h0, 4'h0);
        step(1'b1, 1, 1'b0, 0, 32'h0, 4'h0);
        assert_reset();
        step(1'b1, 2, 1'b1, 3, 32'hDEADBEEF, 4'hF);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, 1, 1'b0, 0, 32'h0, 4'h0);
        check("post_rst_early_b", 32'(bus_b.rd_valid), 32'd0);
        idle(1);
        check("post_rst_rd1_b", bus_b.rd_data, 32'h22);
        step(1'b1, 3, 1'b0, 0, 32'h0, 4'h0);
        idle(2);

        // Random traffic, biased towards same-address collisions.
        for (int i = 0; i < 600; i++) begin
            int ra;
            int wa;
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 255))
                                              : int'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) wa = ra;
            else if ($urandom_range(0, 7) == 0) wa = int'($urandom_range(128, 255));
            else wa = int'($urandom_range(0, 127));
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                 $urandom, 4'($urandom));
        end

        // Sweep every in-range word, then drain.
        for (int i = 0; i < MEM; i++) step(1'b1, i, 1'b0, 0, 32'h0, 4'h0);
        idle(3);
        check("drain_a", 32'(q0.size()), 32'd0);
        check("drain_b", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
